// File: rtl/tt_um_add_sched_jellyant.sv
// Shared 8-bit summing engine: operands are queued into a small FIFO, then a
// controller drains them through one adder into an accumulator and publishes the sum.
module tt_um_add_sched_jellyant #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       acc_q, acc_d;
    logic [7:0]       result_q, result_d;
    logic             carry_q, carry_d;

    logic push_cmd, go_cmd, abort_cmd, ack_cmd;
    logic full, push_ok;
    logic [8:0] sum9;
    logic unused_inputs;

    assign push_cmd  = uio_in[0];
    assign go_cmd    = uio_in[1];
    assign abort_cmd = uio_in[2];
    assign ack_cmd   = uio_in[3];
    assign unused_inputs = &{1'b0, ena, uio_in[7:4]};

    assign full = (count_q == FULL_CNT);
    assign sum9 = {1'b0, acc_q} + {1'b0, mem_q[rd_ptr_q]};

    // Push loses to abort and go in the same cycle and is never taken while draining.
    assign push_ok = push_cmd && !abort_cmd && !go_cmd && (state_q != ST_RUN) && !full;

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        acc_d    = acc_q;
        result_d = result_q;
        carry_d  = carry_q;

        if (abort_cmd) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            if (state_q == ST_RUN) begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go_cmd) begin
                        carry_d = 1'b0;
                        if (count_q != '0) begin
                            acc_d   = 8'h00;
                            state_d = ST_RUN;
                        end else begin
                            result_d = 8'h00;
                            state_d  = ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (count_q != '0) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                        acc_d    = sum9[7:0];
                        carry_d  = carry_q | sum9[8];
                        if (count_q == ONE_CNT) begin
                            result_d = sum9[7:0];
                            state_d  = ST_DONE;
                        end
                    end else begin
                        result_d = acc_q;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ack_cmd) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = ui_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            count_d         = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= 8'h00;
            result_q <= 8'h00;
            carry_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            mem_q    <= mem_d;
        end
    end

    assign uo_out  = result_q;
    assign uio_out = {carry_q, full, (state_q == ST_DONE), (state_q == ST_RUN), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_add_sched_jellyant.sv
// Directed bench for the summing scheduler: a cycle-by-cycle vector table with
// hand-computed outputs, plus an asynchronous mid-run reset sequence.
module tb_tt_um_add_sched_jellyant;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int failures;

    typedef struct {
        logic       push;
        logic       go;
        logic       abort;
        logic       ack;
        logic [7:0] data;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t vecs[$];

    tt_um_add_sched_jellyant #(.FIFO_DEPTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // uio_out layout: {carry_sticky, full, done, busy, 4'b0}
    function automatic logic [7:0] st(input logic c, input logic f, input logic d, input logic b);
        return {c, f, d, b, 4'b0000};
    endfunction

    task automatic add(input logic push, input logic go, input logic abort, input logic ack,
                       input logic [7:0] data, input logic [7:0] exp_uo, input logic [7:0] exp_uio);
        vec_t v;
        v.push = push; v.go = go; v.abort = abort; v.ack = ack;
        v.data = data; v.exp_uo = exp_uo; v.exp_uio = exp_uio;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic push, input logic go, input logic abort, input logic ack,
                         input logic [7:0] data);
        @(negedge clk);
        ui_in  = data;
        uio_in = {4'b0000, ack, abort, go, push};
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ena      = 1'b1;
        ui_in    = 8'h00;
        uio_in   = 8'h00;
        rst_n    = 1'b0;

        // Job 1: 10+20+05, busy for three cycles
        add(1,0,0,0, 8'h10, 8'h00, st(0,0,0,0));
        add(1,0,0,0, 8'h20, 8'h00, st(0,0,0,0));
        add(1,0,0,0, 8'h05, 8'h00, st(0,0,0,0));
        add(0,1,0,0, 8'h00, 8'h00, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h00, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h00, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h35, st(0,0,1,0));
        add(0,0,0,0, 8'h00, 8'h35, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h35, st(0,0,0,0));
        // Job 2: F0+20 overflows; carry holds until the next go
        add(1,0,0,0, 8'hF0, 8'h35, st(0,0,0,0));
        add(1,0,0,0, 8'h20, 8'h35, st(0,0,0,0));
        add(0,1,0,0, 8'h00, 8'h35, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h35, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h10, st(1,0,1,0));
        add(0,0,0,1, 8'h00, 8'h10, st(1,0,0,0));
        add(1,0,0,0, 8'h01, 8'h10, st(1,0,0,0));
        add(0,1,0,0, 8'h00, 8'h10, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h01, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h01, st(0,0,0,0));
        // Job 3: fill to full, fifth push dropped
        add(1,0,0,0, 8'h01, 8'h01, st(0,0,0,0));
        add(1,0,0,0, 8'h02, 8'h01, st(0,0,0,0));
        add(1,0,0,0, 8'h03, 8'h01, st(0,0,0,0));
        add(1,0,0,0, 8'h04, 8'h01, st(0,1,0,0));
        add(1,0,0,0, 8'h05, 8'h01, st(0,1,0,0));
        add(0,1,0,0, 8'h00, 8'h01, st(0,1,0,1));
        add(0,0,0,0, 8'h00, 8'h01, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h01, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h01, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h0A, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h0A, st(0,0,0,0));
        // Empty go: done next cycle, go ignored in DONE
        add(0,1,0,0, 8'h00, 8'h00, st(0,0,1,0));
        add(0,1,0,0, 8'h00, 8'h00, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h00, st(0,0,0,0));
        // Single operand job to leave a nonzero result
        add(1,0,0,0, 8'h07, 8'h00, st(0,0,0,0));
        add(0,1,0,0, 8'h00, 8'h00, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h07, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h07, st(0,0,0,0));
        // Abort on the second RUN cycle keeps the old result and empties the FIFO
        add(1,0,0,0, 8'h11, 8'h07, st(0,0,0,0));
        add(1,0,0,0, 8'h22, 8'h07, st(0,0,0,0));
        add(1,0,0,0, 8'h33, 8'h07, st(0,0,0,0));
        add(1,0,0,0, 8'h44, 8'h07, st(0,1,0,0));
        add(0,1,0,0, 8'h00, 8'h07, st(0,1,0,1));
        add(0,0,0,0, 8'h00, 8'h07, st(0,0,0,1));
        add(0,0,1,0, 8'h00, 8'h07, st(0,0,0,0));
        add(0,1,0,0, 8'h00, 8'h00, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h00, st(0,0,0,0));
        // Push coincident with go and push in RUN are dropped
        add(1,0,0,0, 8'h03, 8'h00, st(0,0,0,0));
        add(1,1,0,0, 8'h04, 8'h00, st(0,0,0,1));
        add(1,0,0,0, 8'h09, 8'h03, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h03, st(0,0,0,0));
        add(0,1,0,0, 8'h00, 8'h00, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h00, st(0,0,0,0));
        add(1,0,0,0, 8'h03, 8'h00, st(0,0,0,0));
        add(1,0,0,0, 8'h05, 8'h00, st(0,0,0,0));
        add(0,1,0,0, 8'h00, 8'h00, st(0,0,0,1));
        add(1,0,0,0, 8'h0A, 8'h00, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h08, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h08, st(0,0,0,0));
        add(0,1,0,0, 8'h00, 8'h00, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h00, st(0,0,0,0));
        // Abort in IDLE flushes the FIFO without changing state
        add(1,0,0,0, 8'h06, 8'h00, st(0,0,0,0));
        add(0,0,1,0, 8'h00, 8'h00, st(0,0,0,0));
        add(0,1,0,0, 8'h00, 8'h00, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h00, st(0,0,0,0));
        // Leave 55 on uo_out before the reset sequence
        add(1,0,0,0, 8'h55, 8'h00, st(0,0,0,0));
        add(0,1,0,0, 8'h00, 8'h00, st(0,0,0,1));
        add(0,0,0,0, 8'h00, 8'h55, st(0,0,1,0));
        add(0,0,0,1, 8'h00, 8'h55, st(0,0,0,0));

        #12;
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].push, vecs[i].go, vecs[i].abort, vecs[i].ack, vecs[i].data);
            check($sformatf("vec%0d_uo_out", i), uo_out, vecs[i].exp_uo);
            check($sformatf("vec%0d_uio_out", i), uio_out, vecs[i].exp_uio);
            check($sformatf("vec%0d_uio_oe", i), uio_oe, 8'hF0);
        end

        // Reset pulsed mid-RUN clears outputs before any clock edge
        drive(1, 0, 0, 0, 8'h0F);
        drive(1, 0, 0, 0, 8'h0F);
        drive(0, 1, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 8'h00);
        check("midrun_uo_out", uo_out, 8'h55);
        check("midrun_uio_out", uio_out, st(0,0,0,1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_uo_out", uo_out, 8'h00);
        check("async_reset_uio_out", uio_out, 8'h00);
        check("async_reset_uio_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        check("post_reset_idle_uo", uo_out, 8'h00);
        check("post_reset_idle_uio", uio_out, 8'h00);
        drive(0, 1, 0, 0, 8'h00);
        check("post_reset_go_uo", uo_out, 8'h00);
        check("post_reset_go_uio", uio_out, st(0,0,1,0));
        drive(0, 0, 0, 1, 8'h00);
        check("post_reset_ack_uio", uio_out, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
